// File: rtl/bp_pkg.sv
// Shared constants and helpers for the branch-prediction controller.
// Counter encodings are width-generic; the localparams give the default-width values.
package bp_pkg;

    localparam int unsigned BP_CWIDTH = 2;

    function automatic logic [31:0] weak_t_fn(int unsigned cw);
        return 32'(1) << (cw - 1);
    endfunction

    function automatic logic [31:0] weak_nt_fn(int unsigned cw);
        return weak_t_fn(cw) - 32'(1);
    endfunction

    function automatic logic [31:0] ctr_max_fn(int unsigned cw);
        return (32'(1) << cw) - 32'(1);
    endfunction

    localparam logic [BP_CWIDTH-1:0] WEAK_T   = BP_CWIDTH'(weak_t_fn(BP_CWIDTH));
    localparam logic [BP_CWIDTH-1:0] WEAK_NT  = BP_CWIDTH'(weak_nt_fn(BP_CWIDTH));
    localparam logic [BP_CWIDTH-1:0] CTR_MAX  = BP_CWIDTH'(ctr_max_fn(BP_CWIDTH));

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state logic for a saturating branch counter.
// A miss seeds the weak state in the direction of the outcome.
module bp_sat_counter
    import bp_pkg::*;
#(
    parameter int unsigned CWIDTH = BP_CWIDTH
) (
    input  logic [CWIDTH-1:0] ctr,
    input  logic              valid,
    input  logic              taken,
    output logic [CWIDTH-1:0] ctr_next
);

    localparam logic [CWIDTH-1:0] C_WEAK_T  = CWIDTH'(weak_t_fn(CWIDTH));
    localparam logic [CWIDTH-1:0] C_WEAK_NT = CWIDTH'(weak_nt_fn(CWIDTH));
    localparam logic [CWIDTH-1:0] C_MAX     = CWIDTH'(ctr_max_fn(CWIDTH));

    always_comb begin
        ctr_next = ctr;
        if (!valid) begin
            ctr_next = taken ? C_WEAK_T : C_WEAK_NT;
        end else if (taken) begin
            if (ctr != C_MAX) ctr_next = ctr + CWIDTH'(1);
        end else begin
            if (ctr != '0) ctr_next = ctr - CWIDTH'(1);
        end
    end

endmodule

// File: rtl/bp_predict_ctrl.sv
// Branch-prediction controller around bp_cache: fetch prediction on port 0, update on port 1.
// Optional macro BP_STATS_EN adds branch / mispredict statistic counters.
module bp_predict_ctrl
    import bp_pkg::*;
#(
    parameter int unsigned AWIDTH = 32,
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned CWIDTH = BP_CWIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AWIDTH-1:0] pc_guess,
    input  logic              is_br_guess,
    input  logic [AWIDTH-1:0] pc_check,
    input  logic              is_br_check,
    input  logic              br_taken_check,
    input  logic              pred_check,
    input  logic              stall,
    output logic              br_pred_taken,
    output logic [AWIDTH-1:0] ra0,
    output logic [AWIDTH-1:0] ra1,
    input  logic [DWIDTH-1:0] dout0,
    input  logic              hit0,
    input  logic [DWIDTH-1:0] dout1,
    input  logic              hit1,
    output logic [AWIDTH-1:0] wa,
    output logic [DWIDTH-1:0] din,
    output logic              we
`ifdef BP_STATS_EN
    ,
    output logic [31:0]       stat_branches,
    output logic [31:0]       stat_mispredicts
`endif
);

    logic              pend_valid;
    logic [AWIDTH-1:0] pend_addr;
    logic [CWIDTH-1:0] pend_ctr;

    logic              byp0;
    logic              byp1;
    logic [CWIDTH-1:0] eff_ctr0;
    logic [CWIDTH-1:0] eff_ctr1;
    logic              valid1;
    logic              capture;
    logic [CWIDTH-1:0] ctr_next;
    logic              unused_bits;

    assign ra0 = pc_guess;
    assign ra1 = pc_check;

    assign we  = pend_valid;
    assign wa  = pend_addr;
    assign din = {{(DWIDTH-CWIDTH){1'b0}}, pend_ctr};

    // The pending entry is one cycle ahead of the cache, so it wins over cache data.
    assign byp0     = pend_valid && (pend_addr == pc_guess);
    assign byp1     = pend_valid && (pend_addr == pc_check);
    assign eff_ctr0 = byp0 ? pend_ctr : dout0[CWIDTH-1:0];
    assign eff_ctr1 = byp1 ? pend_ctr : dout1[CWIDTH-1:0];
    assign valid1   = byp1 || hit1;

    assign br_pred_taken = is_br_guess && (byp0 || hit0) && eff_ctr0[CWIDTH-1];

    assign capture = is_br_check && !stall;

    assign unused_bits = ^{dout0[DWIDTH-1:CWIDTH], dout1[DWIDTH-1:CWIDTH], pred_check};

    bp_sat_counter #(
        .CWIDTH (CWIDTH)
    ) u_sat_counter (
        .ctr      (eff_ctr1),
        .valid    (valid1),
        .taken    (br_taken_check),
        .ctr_next (ctr_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            pend_ctr   <= '0;
        end else if (capture) begin
            pend_valid <= 1'b1;
            pend_addr  <= pc_check;
            pend_ctr   <= ctr_next;
        end else begin
            pend_valid <= 1'b0;
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (capture) begin
            stat_branches <= stat_branches + 32'(1);
            if (pred_check != br_taken_check) stat_mispredicts <= stat_mispredicts + 32'(1);
        end
    end
`endif

endmodule

// File: tb/tb_bp_predict_ctrl.sv
// Directed self-checking bench for bp_predict_ctrl; cache responses are driven by hand.
// Statistic checks are compiled in when BP_STATS_EN is defined.
module tb_bp_predict_ctrl;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] pc_guess, pc_check, ra0, ra1, wa;
    logic          is_br_guess, is_br_check, br_taken_check, pred_check, stall;
    logic          br_pred_taken, hit0, hit1, we;
    logic [DW-1:0] dout0, dout1, din;
`ifdef BP_STATS_EN
    logic [31:0]   stat_branches, stat_mispredicts;
`endif

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    bp_predict_ctrl #(
        .AWIDTH (AW),
        .DWIDTH (DW),
        .CWIDTH (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pc_guess       (pc_guess),
        .is_br_guess    (is_br_guess),
        .pc_check       (pc_check),
        .is_br_check    (is_br_check),
        .br_taken_check (br_taken_check),
        .pred_check     (pred_check),
        .stall          (stall),
        .br_pred_taken  (br_pred_taken),
        .ra0            (ra0),
        .ra1            (ra1),
        .dout0          (dout0),
        .hit0           (hit0),
        .dout1          (dout1),
        .hit1           (hit1),
        .wa             (wa),
        .din            (din),
        .we             (we)
`ifdef BP_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_check(input logic [31:0] pc, input logic taken, input logic hit,
                             input logic [31:0] dout);
        pc_check       = pc;
        is_br_check    = 1'b1;
        br_taken_check = taken;
        hit1           = hit;
        dout1          = dout;
    endtask

    task automatic write_check(input string tag, input logic [31:0] addr, input logic [31:0] data);
        check({tag, "_we"}, 32'(we), 32'd1);
        check({tag, "_wa"}, wa, addr);
        check({tag, "_din"}, din, data);
    endtask

    // Single update against a cache hit, then one drain cycle.
    task automatic sat(input string tag, input logic [31:0] dout, input logic taken,
                       input logic [31:0] exp);
        set_check(32'hA0, taken, 1'b1, dout);
        step();
        write_check(tag, 32'hA0, exp);
        is_br_check = 1'b0;
        step();
        check({tag, "_drain"}, 32'(we), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        pc_guess = '0; pc_check = '0;
        is_br_guess = 0; is_br_check = 0; br_taken_check = 0; pred_check = 0; stall = 0;
        hit0 = 0; hit1 = 0; dout0 = '0; dout1 = '0;
        #2;
        check("rst_we", 32'(we), 32'd0);
        check("rst_wa", wa, 32'd0);
        check("rst_din", din, 32'd0);
        check("rst_pred", 32'(br_pred_taken), 32'd0);
        pc_guess = 32'h1234; pc_check = 32'h5678;
        #1;
        check("ra0", ra0, 32'h1234);
        check("ra1", ra1, 32'h5678);
        step(); step();
        reset = 1'b0;

        // Cold miss taken seeds weak-taken
        set_check(32'hA0, 1'b1, 1'b0, 32'h0);
        step();
        write_check("cold", 32'hA0, 32'h2);
        is_br_check = 1'b0;
        pc_guess = 32'hA0; is_br_guess = 1'b1; hit0 = 1'b0; dout0 = 32'h0;
        #1 check("cold_byp_pred", 32'(br_pred_taken), 32'd1);
        step();
        check("cold_drain", 32'(we), 32'd0);
        hit0 = 1'b1; dout0 = 32'h2;
        #1 check("hit_pred_t", 32'(br_pred_taken), 32'd1);
        dout0 = 32'h1;
        #1 check("hit_pred_nt", 32'(br_pred_taken), 32'd0);
        hit0 = 1'b0; dout0 = 32'h2;
        #1 check("miss_pred", 32'(br_pred_taken), 32'd0);
        hit0 = 1'b1; dout0 = 32'h3; is_br_guess = 1'b0;
        #1 check("nobr_pred", 32'(br_pred_taken), 32'd0);

        // Saturation and plain steps
        sat("sat_hi", 32'h3, 1'b1, 32'h3);
        sat("sat_lo", 32'h0, 1'b0, 32'h0);
        sat("dec", 32'h2, 1'b0, 32'h1);
        sat("inc", 32'h1, 1'b1, 32'h2);

        // Bypass chain from a miss
        set_check(32'hA0, 1'b1, 1'b0, 32'h0);
        step();
        write_check("chain1", 32'hA0, 32'h2);
        pc_guess = 32'hA0; is_br_guess = 1'b1; hit0 = 1'b0;
        #1 check("chain_byp_pred", 32'(br_pred_taken), 32'd1);
        step();
        write_check("chain2", 32'hA0, 32'h3);
        is_br_check = 1'b0; is_br_guess = 1'b0;
        step();

        // Same-cycle lookup sees the older pending value
        set_check(32'hA0, 1'b0, 1'b0, 32'h0);
        step();
        write_check("sim1", 32'hA0, 32'h1);
        br_taken_check = 1'b1;
        pc_guess = 32'hA0; is_br_guess = 1'b1; hit0 = 1'b0;
        #1 check("sim_old_pred", 32'(br_pred_taken), 32'd0);
        step();
        write_check("sim2", 32'hA0, 32'h2);
        check("sim_new_pred", 32'(br_pred_taken), 32'd1);
        is_br_check = 1'b0; is_br_guess = 1'b0;
        step();

        // Different tag does not disturb 0xA0
        set_check(32'h1A0, 1'b0, 1'b0, 32'h0);
        pc_guess = 32'hA0; is_br_guess = 1'b1; hit0 = 1'b1; dout0 = 32'h3;
        step();
        write_check("tag", 32'h1A0, 32'h1);
        check("tag_a0_pred", 32'(br_pred_taken), 32'd1);
        is_br_check = 1'b0; is_br_guess = 1'b0;
        step();

        // Different PCs back to back
        set_check(32'hB0, 1'b1, 1'b0, 32'h0);
        step();
        write_check("pcb", 32'hB0, 32'h2);
        set_check(32'hC0, 1'b1, 1'b0, 32'h0);
        step();
        write_check("pcc", 32'hC0, 32'h2);
        is_br_check = 1'b0;
        step();
        check("pcc_drain", 32'(we), 32'd0);

        // Stall blocks capture but not the pending write
        set_check(32'hD0, 1'b1, 1'b0, 32'h0);
        step();
        pc_check = 32'hE0; stall = 1'b1;
        #1 write_check("stall_pend", 32'hD0, 32'h2);
        step();
        check("stall_we", 32'(we), 32'd0);
        is_br_check = 1'b0; stall = 1'b0;
        step();

        // Asynchronous reset discards the pending write
        set_check(32'hF0, 1'b1, 1'b0, 32'h0);
        step();
        check("mid_we_pre", 32'(we), 32'd1);
        is_br_check = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("mid_we", 32'(we), 32'd0);
        check("mid_wa", wa, 32'd0);
        check("mid_din", din, 32'd0);
        step();
        check("mid_we_edge", 32'(we), 32'd0);
        reset = 1'b0;

`ifdef BP_STATS_EN
        check("stat_br_rst", stat_branches, 32'd0);
        check("stat_mp_rst", stat_mispredicts, 32'd0);
        set_check(32'h100, 1'b1, 1'b0, 32'h0); pred_check = 1'b1;
        step();
        set_check(32'h104, 1'b1, 1'b0, 32'h0); pred_check = 1'b0;
        step();
        set_check(32'h108, 1'b0, 1'b0, 32'h0); pred_check = 1'b0;
        step();
        set_check(32'h10C, 1'b1, 1'b0, 32'h0); pred_check = 1'b0; stall = 1'b1;
        step();
        is_br_check = 1'b0; stall = 1'b0;
        check("stat_br", stat_branches, 32'd3);
        check("stat_mp", stat_mispredicts, 32'd1);
        reset = 1'b1;
        #1;
        check("stat_br_clr", stat_branches, 32'd0);
        check("stat_mp_clr", stat_mispredicts, 32'd0);
        step();
        reset = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
